// File: rtl/ook_frame_ctrl.sv
// ook_frame_ctrl: schedules preamble / payload / guard-gap symbols onto the OOK DDS keying input.
// Define OOK_MANCHESTER_EN to send each payload bit as two Manchester half-symbols (1->10, 0->01).
module ook_frame_ctrl #(
   parameter int PER_W         = 16,
   parameter int PREAMBLE_SYMS = 8,
   parameter int GAP_SYMS      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PER_W-1:0] sym_period,
   input  logic [7:0]       data_in,
   input  logic             data_last,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             ook_data,
   output logic             sym_strobe,
   output logic             busy,
   output logic             frame_done,
   output logic             underrun
);

   localparam int MAX_A    = (PREAMBLE_SYMS > 8) ? PREAMBLE_SYMS : 8;
   localparam int MAX_SYMS = (GAP_SYMS > MAX_A) ? GAP_SYMS : MAX_A;
   localparam int CNT_W    = $clog2(MAX_SYMS);

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_SYMS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_SYMS - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(7);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_GAP} state_t;

   state_t           state, state_n;
   logic [PER_W-1:0] sym_cnt, sym_cnt_n;
   logic [PER_W-1:0] period, period_n;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic [7:0]       hold, hold_n;
   logic [7:0]       shift, shift_n;
   logic             hold_last, hold_last_n;
   logic             hold_full, hold_full_n;
   logic             shift_last, shift_last_n;
   logic             ook_n, strobe_n, done_n, under_n;
   logic             wrap, bit_done, accept;
`ifdef OOK_MANCHESTER_EN
   logic             half, half_n;
`endif

   assign wrap   = (sym_cnt == period);
   assign accept = data_valid & data_ready;
   assign busy   = (state != S_IDLE);
`ifdef OOK_MANCHESTER_EN
   assign bit_done = wrap & half;
`else
   assign bit_done = wrap;
`endif

   always_comb begin
      state_n      = state;
      sym_cnt_n    = wrap ? '0 : sym_cnt + PER_W'(1);
      period_n     = period;
      bit_cnt_n    = bit_cnt;
      hold_n       = hold;
      hold_last_n  = hold_last;
      hold_full_n  = hold_full;
      shift_n      = shift;
      shift_last_n = shift_last;
      ook_n        = ook_data;
      strobe_n     = 1'b0;
      done_n       = 1'b0;
      under_n      = 1'b0;
`ifdef OOK_MANCHESTER_EN
      half_n       = half;
`endif

      case (state)
         S_IDLE: begin
            sym_cnt_n = '0;
            ook_n     = 1'b0;
            if (hold_full) begin
               period_n  = sym_period;
               state_n   = S_PREAMBLE;
               bit_cnt_n = '0;
               ook_n     = 1'b1;
               strobe_n  = 1'b1;
            end
         end

         // Preamble symbol k carries ~k[0]; the byte in hold is committed on the final boundary.
         S_PREAMBLE: begin
            if (wrap) begin
               strobe_n = 1'b1;
               if (bit_cnt == PRE_LAST) begin
                  state_n      = S_DATA;
                  bit_cnt_n    = '0;
                  shift_n      = hold;
                  shift_last_n = hold_last;
                  hold_full_n  = 1'b0;
                  ook_n        = hold[7];
`ifdef OOK_MANCHESTER_EN
                  half_n       = 1'b0;
`endif
               end else begin
                  bit_cnt_n = bit_cnt + CNT_W'(1);
                  ook_n     = bit_cnt[0];
               end
            end
         end

         S_DATA: begin
            if (wrap) begin
               strobe_n = 1'b1;
            end
`ifdef OOK_MANCHESTER_EN
            if (wrap && !half) begin
               half_n = 1'b1;
               ook_n  = ~shift[7];
            end
`endif
            if (bit_done) begin
`ifdef OOK_MANCHESTER_EN
               half_n = 1'b0;
`endif
               if (bit_cnt != BIT_LAST) begin
                  bit_cnt_n = bit_cnt + CNT_W'(1);
                  shift_n   = {shift[6:0], 1'b0};
                  ook_n     = shift[6];
               end else if (shift_last) begin
                  state_n   = S_GAP;
                  bit_cnt_n = '0;
                  ook_n     = 1'b0;
               end else if (hold_full) begin
                  bit_cnt_n    = '0;
                  shift_n      = hold;
                  shift_last_n = hold_last;
                  hold_full_n  = 1'b0;
                  ook_n        = hold[7];
               end else begin
                  // Host starved the serialiser: abandon the frame through the guard gap.
                  under_n   = 1'b1;
                  state_n   = S_GAP;
                  bit_cnt_n = '0;
                  ook_n     = 1'b0;
               end
            end
         end

         S_GAP: begin
            ook_n = 1'b0;
            if (wrap) begin
               if (bit_cnt == GAP_LAST) begin
                  state_n   = S_IDLE;
                  bit_cnt_n = '0;
                  sym_cnt_n = '0;
                  done_n    = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt + CNT_W'(1);
                  strobe_n  = 1'b1;
               end
            end
         end

         default: state_n = S_IDLE;
      endcase

      if (accept) begin
         hold_n      = data_in;
         hold_last_n = data_last;
         hold_full_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         sym_cnt    <= '0;
         period     <= '0;
         bit_cnt    <= '0;
         hold       <= '0;
         hold_last  <= 1'b0;
         hold_full  <= 1'b0;
         shift      <= '0;
         shift_last <= 1'b0;
         ook_data   <= 1'b0;
         sym_strobe <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         data_ready <= 1'b0;
`ifdef OOK_MANCHESTER_EN
         half       <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sym_cnt    <= sym_cnt_n;
         period     <= period_n;
         bit_cnt    <= bit_cnt_n;
         hold       <= hold_n;
         hold_last  <= hold_last_n;
         hold_full  <= hold_full_n;
         shift      <= shift_n;
         shift_last <= shift_last_n;
         ook_data   <= ook_n;
         sym_strobe <= strobe_n;
         frame_done <= done_n;
         underrun   <= under_n;
         data_ready <= ~hold_full_n;
`ifdef OOK_MANCHESTER_EN
         half       <= half_n;
`endif
      end
   end

endmodule

// File: doc/ook_frame_ctrl.md
# ook_frame_ctrl

Symbol scheduler that feeds the `ook_data` keying input of the OOK DDS transmitter. It accepts payload bytes over a valid/ready handshake and builds a frame: alternating preamble, payload serialised MSB-first, then a silent guard gap. It times every symbol from a programmable clock-count period and reports frame activity, completion and underrun to the host logic.

## Interface
Parameters:
- `PER_W`, 16: width of `sym_period`.
- `PREAMBLE_SYMS`, 8: preamble length in symbols; must be even and ≥2.
- `GAP_SYMS`, 4: guard-gap length in symbols; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sym_period`  in  PER_W  clocks per symbol minus 1; sampled only on IDLE→PREAMBLE.
- `data_in`  in  8  payload byte.
- `data_last`  in  1  marks `data_in` as the final byte of the frame.
- `data_valid`  in  1  byte offered.
- `data_ready`  out  1  holding register empty; a byte transfers when `data_valid & data_ready` is high at a rising edge.
- `ook_data`  out  1  carrier key to the DDS; 1 = carrier on.
- `sym_strobe`  out  1  one-clock pulse on the first clock of every symbol (or half-symbol).
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-clock pulse on the GAP→IDLE transition.
- `underrun`  out  1  one-clock pulse when payload starves mid-frame.

## Operation
- Storage:
  - 1-byte holding register (`hold`, `hold_last`, `hold_full`).
  - 8-bit shift register with its own last flag.
  - Bit counter, symbol counter (PER_W bits) and a latched period.
- `data_ready` is `~hold_full`, registered.
- States:
  - IDLE: `ook_data`=0. When `hold_full` is set, latch `sym_period` and go to PREAMBLE.
  - PREAMBLE: emits PREAMBLE_SYMS symbols of alternating 1,0,1,0…, starting with 1. On the last preamble symbol boundary, move `hold` into the shift register, clear `hold_full`, and go to DATA.
  - DATA: emits shift-register bits MSB-first, one bit per symbol. After bit 0 completes:
    - Shift-register last flag set: go to GAP.
    - Else `hold_full` set: reload from `hold` and stay in DATA. There is no gap between bytes.
    - Else: pulse `underrun` and go to GAP. The frame is aborted.
  - GAP: `ook_data`=0 for GAP_SYMS symbols, then pulse `frame_done` and go to IDLE.
- Symbol counter:
  - Counts 0..latched period, then wraps to 0.
  - A symbol boundary is the clock where it wraps.
  - `sym_period`=0 gives one clock per symbol.
- Bytes are accepted in any state whenever `hold_full`=0. A byte accepted during GAP or IDLE starts the next frame after the current one ends.
- A change of `sym_period` while `busy` has no effect until the next frame.
- Reset while busy:
  - Returns immediately to IDLE and discards hold and shift contents.
  - No `frame_done` or `underrun` pulse is issued.
- Reset values: `ook_data`=0, `data_ready`=0, `sym_strobe`=0, `busy`=0, `frame_done`=0, `underrun`=0, state IDLE, all counters 0.

## Timing
- `data_ready` rises on the first rising edge after `rst` deasserts.
- Byte accepted in IDLE at edge N:
  - `hold_full`=1 and `data_ready`=0 after edge N.
  - `busy`=1, `ook_data`=1 and `sym_strobe`=1 after edge N+1.
- Each symbol lasts exactly `sym_period`+1 clocks. `ook_data` changes only on symbol boundaries.
- The first payload bit appears PREAMBLE_SYMS·(P+1) clocks after the first preamble clock, where P is the latched period.
- `data_ready` reasserts on the clock after `hold` is moved into the shift register.
- Simultaneous acceptance and reload on the same edge is impossible, because acceptance requires `hold_full`=0.
- `underrun` and `frame_done` are never high in the same cycle.
- Frame length, no underrun: (PREAMBLE_SYMS + 8·bytes + GAP_SYMS)·(P+1) clocks of `busy`.

## Configuration
- `OOK_MANCHESTER_EN` defined:
  - Every payload bit is sent as two half-symbols of `sym_period`+1 clocks each: 1→(1,0), 0→(0,1).
  - `sym_strobe` pulses per half-symbol.
  - Preamble and gap are unchanged.
  - Payload duration doubles.
- Undefined: payload is plain on/off NRZ, one symbol per bit.

## Test plan
- Reset release, no stimulus → `data_ready`=1 after one clock; `ook_data`=0, `busy`=0 indefinitely.
- `sym_period`=3, one byte 0xA5 with `data_last`=1, defaults:
  - `ook_data` = 10101010, then 10100101, then 0000, each symbol 4 clocks.
  - `busy` high for exactly 80 clocks, then a single `frame_done` pulse.
- `sym_period`=0, three bytes 0xFF, 0x00, 0x81 (last on 0x81), host keeps `valid` high → 24 contiguous payload symbols with no inter-byte gap; `underrun` never pulses.
- Two bytes, first without `last`, second withheld until 20 clocks after the first byte completes → `underrun` pulses once at the byte-0 boundary, GAP follows, `frame_done` pulses.
- `rst` low mid-DATA, with `sym_period` changed from 3 to 1 during the frame:
  - All outputs return to their reset values asynchronously.
  - The next frame uses period 1 (2 clocks per symbol).
- `OOK_MANCHESTER_EN`, `sym_period`=1, byte 0x80 last → payload halves 10,01,01,01,01,01,01,01, 2 clocks each; `sym_strobe` count = 8+16+4.
